// File: rtl/hilo_muldiv_unit.sv
// HI/LO multiply/divide unit for the openMIPS execute stage.
// Multiplies use a registered product pipeline of MUL_STAGES registers. Divides use a
// restoring radix-2 engine: one init cycle, WIDTH iterations, one fix-up/commit cycle.
// The unit owns HI/LO. Direct MTHI/MTLO writes are accepted only while the unit is idle.
module hilo_muldiv_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] opdata1_i,
    input  logic [WIDTH-1:0] opdata2_i,
    input  logic             annul_i,
    input  logic             wr_hi_i,
    input  logic             wr_lo_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             busy_o,
    output logic             ready_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_STAGES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV_INIT,
        S_DIV_ITER,
        S_DIV_FIX
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ready_q;
    logic [WIDTH-1:0]  hi_q, lo_q;

    // Operation context latched at accept (datapath, not reset)
    logic [WIDTH-1:0]  a_q, b_q;
    logic [2:0]        op_q;
    logic [2*WIDTH-1:0] prod_q [MUL_STAGES];
    logic [WIDTH-1:0]  rem_q, quo_q, dvs_q;
    logic              div0_q;

    logic              accept;
    logic              mul_commit, div_commit;

    // Conditional two's-complement negation used for abs() and sign fix-up
    function automatic logic [WIDTH-1:0] cond_neg(input logic neg, input logic [WIDTH-1:0] v);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

    // Input operands extended to 2*WIDTH so a plain modular multiply gives the signed
    // or unsigned full product; odd op codes are the unsigned variants.
    logic              sgn_in;
    logic [2*WIDTH-1:0] ext_a, ext_b, prod_in;

    // Divide datapath helpers
    logic              sgn_q, neg1, neg2;
    logic [WIDTH:0]    shifted;
    logic [WIDTH+1:0]  diff;

    // Commit values
    logic [2*WIDTH-1:0] acc, mul_res;
    logic [WIDTH-1:0]  div_hi, div_lo;

    // Combinational datapath: product input, divide step and commit values
    always_comb begin
        sgn_in  = ~op_i[0];
        ext_a   = {{WIDTH{sgn_in & opdata1_i[WIDTH-1]}}, opdata1_i};
        ext_b   = {{WIDTH{sgn_in & opdata2_i[WIDTH-1]}}, opdata2_i};
        prod_in = ext_a * ext_b;

        sgn_q   = ~op_q[0];
        neg1    = sgn_q & a_q[WIDTH-1];
        neg2    = sgn_q & b_q[WIDTH-1];
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, dvs_q};

        acc = {hi_q, lo_q};
        case (op_q[2:1])
            2'b10:   mul_res = acc + prod_q[MUL_STAGES-1];
            2'b11:   mul_res = acc - prod_q[MUL_STAGES-1];
            default: mul_res = prod_q[MUL_STAGES-1];
        endcase

        if (div0_q) begin
            div_hi = a_q;
            div_lo = '1;
        end else begin
            div_hi = cond_neg(neg1, rem_q);
            div_lo = cond_neg(neg1 ^ neg2, quo_q);
        end
    end

    // Next-state logic; annul while busy overrides every other transition
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        mul_commit = 1'b0;
        div_commit = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i && !annul_i) begin
                    accept  = 1'b1;
                    cnt_d   = '0;
                    state_d = (op_i[2:1] == 2'b01) ? S_DIV_INIT : S_MUL;
                end
            end
            S_MUL: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == MUL_LAST) begin
                    mul_commit = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            S_DIV_INIT: begin
                cnt_d   = '0;
                state_d = (b_q == '0) ? S_DIV_FIX : S_DIV_ITER;
            end
            S_DIV_ITER: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == DIV_LAST) state_d = S_DIV_FIX;
            end
            S_DIV_FIX: begin
                div_commit = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (annul_i && state_q != S_IDLE) begin
            state_d    = S_IDLE;
            mul_commit = 1'b0;
            div_commit = 1'b0;
        end
    end

    // Control registers and architectural HI/LO
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= mul_commit | div_commit;
            if (mul_commit) begin
                hi_q <= mul_res[2*WIDTH-1:WIDTH];
                lo_q <= mul_res[WIDTH-1:0];
            end else if (div_commit) begin
                hi_q <= div_hi;
                lo_q <= div_lo;
            end else if (state_q == S_IDLE) begin
                if (wr_hi_i) hi_q <= wdata_i;
                if (wr_lo_i) lo_q <= wdata_i;
            end
        end
    end

    // Datapath registers: operand latch, product pipeline, divide engine
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q  <= opdata1_i;
            b_q  <= opdata2_i;
            op_q <= op_i;
        end
        prod_q[0] <= prod_in;
        for (int k = 1; k < MUL_STAGES; k++) prod_q[k] <= prod_q[k-1];
        if (state_q == S_DIV_INIT) begin
            rem_q  <= '0;
            quo_q  <= cond_neg(neg1, a_q);
            dvs_q  <= cond_neg(neg2, b_q);
            div0_q <= (b_q == '0);
        end else if (state_q == S_DIV_ITER) begin
            if (!diff[WIDTH+1]) begin
                rem_q <= diff[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_q <= shifted[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign busy_o  = (state_q != S_IDLE);
    assign ready_o = ready_q;
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit (WIDTH=32, MUL_STAGES=2).
module tb_hilo_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_i;
    logic [2:0]   op_i;
    logic [W-1:0] opdata1_i, opdata2_i;
    logic         annul_i, wr_hi_i, wr_lo_i;
    logic [W-1:0] wdata_i;
    logic         busy_o, ready_o;
    logic [W-1:0] hi_o, lo_o;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [2:0] MULT = 3'b000, MULTU = 3'b001, DIV = 3'b010, DIVU = 3'b011,
                           MADD = 3'b100, MADDU = 3'b101, MSUB = 3'b110, MSUBU = 3'b111;

    hilo_muldiv_unit #(.WIDTH(W), .MUL_STAGES(2)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
        .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .annul_i(annul_i),
        .wr_hi_i(wr_hi_i), .wr_lo_i(wr_lo_i), .wdata_i(wdata_i),
        .busy_o(busy_o), .ready_o(ready_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] d1, d2;
        logic [W-1:0] pre_hi, pre_lo;
        logic [W-1:0] exp_hi, exp_lo;
        int           lat;
    } vec_t;

    vec_t vecs[13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_hilo(input logic [W-1:0] h, input logic [W-1:0] l);
        wr_hi_i = 1'b1; wdata_i = h;
        tick();
        wr_hi_i = 1'b0; wr_lo_i = 1'b1; wdata_i = l;
        tick();
        wr_lo_i = 1'b0;
    endtask

    // Issue one operation, wait (bounded) for ready_o, check latency, busy and result
    task automatic exec_op(input string nm, input logic [2:0] op, input logic [W-1:0] d1,
                           input logic [W-1:0] d2, input logic [W-1:0] ehi,
                           input logic [W-1:0] elo, input int lat);
        int   n;
        logic got, busy_ok;
        op_i = op; opdata1_i = d1; opdata2_i = d2; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        n = 0; got = 1'b0; busy_ok = 1'b1;
        while (!got && n < 100) begin
            if (busy_o !== 1'b1) busy_ok = 1'b0;
            tick();
            n++;
            got = ready_o;
        end
        if (!got) begin
            n_tests++; n_fail++;
            $display("FAIL %s_timeout: no ready_o within %0d edges, expected after %0d", nm, n, lat);
        end else begin
            chk({nm, "_lat"}, W'(n), W'(lat));
            chk({nm, "_busy_during"}, W'(busy_ok), W'(1));
            chk({nm, "_busy_at_ready"}, W'(busy_o), W'(0));
            chk({nm, "_hi"}, hi_o, ehi);
            chk({nm, "_lo"}, lo_o, elo);
            tick();
            chk({nm, "_ready_pulse"}, W'(ready_o), W'(0));
            chk({nm, "_hi_hold"}, hi_o, ehi);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   k;
        logic seen_bad;

        //           op     d1            d2            pre_hi        pre_lo        exp_hi        exp_lo        lat
        vecs[0]  = '{MULT,  32'hFFFFFFFB, 32'h00000006, 32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFE2, 2};
        vecs[1]  = '{MULTU, 32'hFFFFFFFB, 32'h00000006, 32'h0,        32'h0,        32'h00000005, 32'hFFFFFFE2, 2};
        vecs[2]  = '{DIV,   32'hFFFFFFF9, 32'h00000002, 32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFD, 34};
        vecs[3]  = '{DIVU,  32'h00000011, 32'h00000003, 32'h0,        32'h0,        32'h00000002, 32'h00000005, 34};
        vecs[4]  = '{MADD,  32'h00010000, 32'h00010000, 32'h0,        32'h1,        32'h00000001, 32'h00000001, 2};
        vecs[5]  = '{MSUBU, 32'h00000001, 32'h00000001, 32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 2};
        vecs[6]  = '{DIVU,  32'h12345678, 32'h00000000, 32'h0,        32'h0,        32'h12345678, 32'hFFFFFFFF, 2};
        vecs[7]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h0,        32'h00000000, 32'h80000000, 34};
        vecs[8]  = '{DIV,   32'h00000007, 32'hFFFFFFFE, 32'h0,        32'h0,        32'h00000001, 32'hFFFFFFFD, 34};
        vecs[9]  = '{MSUB,  32'h00000003, 32'hFFFFFFFC, 32'h0,        32'hA,        32'h00000000, 32'h00000016, 2};
        vecs[10] = '{MADDU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000000, 2};
        vecs[11] = '{DIV,   32'hFFFFFFF0, 32'h00000000, 32'h0,        32'h0,        32'hFFFFFFF0, 32'hFFFFFFFF, 2};
        vecs[12] = '{MULT,  32'h80000000, 32'h80000000, 32'h0,        32'h0,        32'h40000000, 32'h00000000, 2};

        rst = 1'b1; start_i = 1'b0; op_i = 3'b0; opdata1_i = '0; opdata2_i = '0;
        annul_i = 1'b0; wr_hi_i = 1'b0; wr_lo_i = 1'b0; wdata_i = '0;
        tick(); tick();
        chk("reset_busy", W'(busy_o), W'(0));
        chk("reset_ready", W'(ready_o), W'(0));
        chk("reset_hi", hi_o, '0);
        chk("reset_lo", lo_o, '0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 13; i++) begin
            set_hilo(vecs[i].pre_hi, vecs[i].pre_lo);
            chk($sformatf("v%0d_pre_hi", i), hi_o, vecs[i].pre_hi);
            chk($sformatf("v%0d_pre_lo", i), lo_o, vecs[i].pre_lo);
            exec_op($sformatf("v%0d", i), vecs[i].op, vecs[i].d1, vecs[i].d2,
                    vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].lat);
        end

        // Simultaneous MTHI/MTLO
        wr_hi_i = 1'b1; wr_lo_i = 1'b1; wdata_i = 32'h00000077;
        tick();
        wr_hi_i = 1'b0; wr_lo_i = 1'b0;
        chk("both_wr_hi", hi_o, 32'h77);
        chk("both_wr_lo", lo_o, 32'h77);

        // start_i together with annul_i while idle is dropped
        op_i = MULT; opdata1_i = 32'd2; opdata2_i = 32'd3; start_i = 1'b1; annul_i = 1'b1;
        tick();
        start_i = 1'b0; annul_i = 1'b0;
        chk("idle_annul_busy", W'(busy_o), W'(0));
        tick(); tick(); tick();
        chk("idle_annul_ready", W'(ready_o), W'(0));
        chk("idle_annul_lo", lo_o, 32'h77);

        // Annul a divide on its 10th busy cycle; start/MTHI while busy are ignored
        set_hilo(32'h0000AAAA, 32'h00005555);
        op_i = DIV; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (k = 1; k < 10; k++) begin
            if (k == 2) begin
                start_i = 1'b1; op_i = MULT; wr_hi_i = 1'b1; wdata_i = 32'hDEAD;
            end
            tick();
            start_i = 1'b0; wr_hi_i = 1'b0;
        end
        chk("annul_busy_before", W'(busy_o), W'(1));
        chk("annul_wr_ignored", hi_o, 32'h0000AAAA);
        annul_i = 1'b1;
        tick();
        annul_i = 1'b0;
        chk("annul_busy_after", W'(busy_o), W'(0));
        chk("annul_ready", W'(ready_o), W'(0));
        chk("annul_hi", hi_o, 32'h0000AAAA);
        chk("annul_lo", lo_o, 32'h00005555);
        seen_bad = 1'b0;
        for (int j = 0; j < 40; j++) begin
            tick();
            if (ready_o !== 1'b0 || busy_o !== 1'b0) seen_bad = 1'b1;
        end
        chk("annul_quiet", W'(seen_bad), W'(0));

        // Reset in the middle of a divide, then a MULT right after release
        op_i = DIV; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int j = 0; j < 5; j++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", W'(busy_o), W'(0));
        chk("midrst_ready", W'(ready_o), W'(0));
        chk("midrst_hi", hi_o, '0);
        chk("midrst_lo", lo_o, '0);
        exec_op("post_rst_mult", MULT, 32'd3, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFA, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
